// File: rtl/contact_scheduler.sv
// Prime-pulse sequencer: emits primes 2..MAX_PRIME as pulse-count commands over valid/ready.
// Trial division by repeated subtraction; command outputs are registered and held until accepted.
module contact_scheduler #(
  parameter int MAX_PRIME = 31,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 one_shot,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [CNT_WIDTH-1:0] cmd_count,
  output logic                 cmd_last,
  output logic                 busy,
  output logic                 seq_done,
  output logic [31:0]          seq_cnt
);

  function automatic int calc_last_prime(int m);
    int  lp;
    bit  prime;
    lp = 2;
    for (int c = 2; c <= m; c++) begin
      prime = 1'b1;
      for (int d = 2; d * d <= c; d++)
        if (c % d == 0) prime = 1'b0;
      if (prime) lp = c;
    end
    return lp;
  endfunction

  localparam int                   LAST_PRIME = calc_last_prime(MAX_PRIME);
  localparam logic [CNT_WIDTH-1:0] LAST_C     = CNT_WIDTH'(LAST_PRIME);
  localparam logic [CNT_WIDTH-1:0] TWO        = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH:0]   MAX_C      = (CNT_WIDTH+1)'(MAX_PRIME);

  typedef enum logic [2:0] {S_IDLE, S_NEXT, S_TEST, S_DIV, S_ISSUE, S_END} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cand_q, cand_d;
  logic [CNT_WIDTH-1:0]   div_q, div_d;
  logic [CNT_WIDTH-1:0]   res_q, res_d;
  logic                   os_q, os_d;
  logic                   blk_q, blk_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   done_q, done_d;
  logic [31:0]            seq_cnt_q, seq_cnt_d;
  logic [CNT_WIDTH:0]     cand_nxt;
  logic [2*CNT_WIDTH-1:0] div_sq;
  logic                   hs;

  assign cand_nxt = {1'b0, cand_q} + 1'b1;
  assign div_sq   = {{CNT_WIDTH{1'b0}}, div_q} * {{CNT_WIDTH{1'b0}}, div_q};
  assign hs       = valid_q && cmd_ready;

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    div_d     = div_q;
    res_d     = res_q;
    os_d      = os_q;
    blk_d     = blk_q;
    // blk_q holds off a one-shot restart until enable has been seen low
    if (!enable) blk_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && !blk_q) begin
          os_d    = one_shot;
          cand_d  = TWO;
          state_d = S_ISSUE;
        end
      end
      S_NEXT: begin
        cand_d  = cand_nxt[CNT_WIDTH-1:0];
        div_d   = TWO;
        state_d = (cand_nxt > MAX_C) ? S_IDLE : S_TEST;
      end
      S_TEST: begin
        if (div_sq > {{CNT_WIDTH{1'b0}}, cand_q}) begin
          state_d = S_ISSUE;
        end else begin
          res_d   = cand_q;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (res_q >= div_q) begin
          res_d = res_q - div_q;
        end else if (res_q == '0) begin
          state_d = S_NEXT;
        end else begin
          div_d   = div_q + 1'b1;
          state_d = S_TEST;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) state_d = last_q ? S_END : S_NEXT;
      end
      S_END: begin
        if (enable && !os_q) begin
          os_d    = one_shot;
          cand_d  = TWO;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
          if (enable) blk_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    valid_d   = (state_d == S_ISSUE);
    last_d    = valid_d && (cand_d == LAST_C);
    done_d    = hs && last_q;
    seq_cnt_d = seq_cnt_q + {31'd0, done_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cand_q    <= '0;
      div_q     <= '0;
      res_q     <= '0;
      os_q      <= 1'b0;
      blk_q     <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      seq_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      div_q     <= div_d;
      res_q     <= res_d;
      os_q      <= os_d;
      blk_q     <= blk_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
      seq_cnt_q <= seq_cnt_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_count = cand_q;
  assign cmd_last  = last_q;
  assign busy      = (state_q != S_IDLE);
  assign seq_done  = done_q;
  assign seq_cnt   = seq_cnt_q;

endmodule

// File: tb/tb_contact_scheduler.sv
// Scoreboard bench for contact_scheduler: MAX_PRIME=13 instance for the main scenarios,
// MAX_PRIME=2 instance for the single-command degenerate case.
module tb_contact_scheduler;

  logic        clk;
  logic        rst;
  logic        enable, one_shot, cmd_ready;
  logic        cmd_valid, cmd_last, busy, seq_done;
  logic [7:0]  cmd_count;
  logic [31:0] seq_cnt;

  logic        en2, os2, rdy2;
  logic        cmd_valid2, cmd_last2, busy2, seq_done2;
  logic [7:0]  cmd_count2;
  logic [31:0] seq_cnt2;

  int          n_chk = 0;
  int          n_pass = 0;
  int          rdy_mode = 0;
  logic [8:0]  sb[$];
  int          primes13[6] = '{2, 3, 5, 7, 11, 13};

  int          mdl_cnt, gap, gap_prime, last_acc, n2;
  logic        exp_done, stall_q, wait_v, gap_last, hs2;
  logic        chk_restart = 1'b0;
  logic [8:0]  hold_e, exp_e;

  contact_scheduler #(.MAX_PRIME(13), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .one_shot(one_shot),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_count(cmd_count),
    .cmd_last(cmd_last), .busy(busy), .seq_done(seq_done), .seq_cnt(seq_cnt)
  );

  contact_scheduler #(.MAX_PRIME(2), .CNT_WIDTH(8)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .one_shot(os2),
    .cmd_valid(cmd_valid2), .cmd_ready(rdy2), .cmd_count(cmd_count2),
    .cmd_last(cmd_last2), .busy(busy2), .seq_done(seq_done2), .seq_cnt(seq_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push_seq();
    for (int i = 0; i < 6; i++) sb.push_back({(i == 5) ? 1'b1 : 1'b0, 8'(primes13[i])});
  endtask

  task automatic wait_sb_empty(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk); #1;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(negedge clk); #1;
    end
    check(tag, busy, 0);
  endtask

  task automatic wait_acc(input int val, input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (last_acc == val) break;
      @(negedge clk); #1;
    end
    check(tag, last_acc, val);
  endtask

  // Ready changes only just after the rising edge so handshakes are unambiguous at sampling time
  initial begin
    cmd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       cmd_ready = 1'b0;
        1:       cmd_ready = 1'b1;
        default: cmd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      mdl_cnt = 0; exp_done = 0; stall_q = 0; wait_v = 0; gap = 0; last_acc = 0;
      gap_last = 0; gap_prime = 0;
    end else begin
      if (seq_done || exp_done) begin
        check("seq_done", seq_done, exp_done);
        check("seq_cnt", seq_cnt, mdl_cnt);
      end
      exp_done = 0;
      if (stall_q) begin
        check("hold_vld", cmd_valid, 1);
        check("hold_cmd", {cmd_last, cmd_count}, hold_e);
      end
      stall_q = 0;
      if (wait_v) begin
        gap++;
        if (cmd_valid) begin
          wait_v = 0;
          if (gap_last && chk_restart) check("restart_gap", gap, 2);
          else if (!gap_last && gap_prime == 2) check("gap_after_2", gap, 3);
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          exp_e = sb.pop_front();
          check("cmd", {cmd_last, cmd_count}, exp_e);
          if (exp_e[8]) begin mdl_cnt++; exp_done = 1; end
        end
        last_acc = cmd_count;
        wait_v = 1; gap = 0; gap_last = cmd_last; gap_prime = cmd_count;
      end else if (cmd_valid) begin
        stall_q = 1;
        hold_e  = {cmd_last, cmd_count};
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      n2 = 0; hs2 = 0;
    end else begin
      if (hs2 || seq_done2) begin
        check("deg_done", seq_done2, hs2);
        check("deg_seqcnt", seq_cnt2, n2);
      end
      hs2 = 0;
      if (cmd_valid2 && rdy2) begin
        check("deg_cmd", {cmd_last2, cmd_count2}, 9'h102);
        n2++;
        hs2 = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; enable = 1'b0; one_shot = 1'b0;
    en2 = 1'b0; os2 = 1'b0; rdy2 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_count", cmd_count, 0);
    check("rst_last", cmd_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", seq_done, 0);
    check("rst_seqcnt", seq_cnt, 0);
    #1 rst = 1'b1;

    // continuous, always ready, three sequences
    chk_restart = 1'b1;
    rdy_mode = 1;
    repeat (3) push_seq();
    @(negedge clk); #1;
    enable = 1'b1;
    wait_sb_empty("cont_drain");
    enable = 1'b0;
    wait_idle("cont_idle");
    chk_restart = 1'b0;
    check("cont_seqcnt", seq_cnt, 3);

    // random backpressure, two sequences
    rdy_mode = 2;
    repeat (2) push_seq();
    enable = 1'b1;
    wait_sb_empty("bp_drain");
    enable = 1'b0;
    wait_idle("bp_idle");
    check("bp_seqcnt", seq_cnt, 5);

    // one-shot with enable held high
    rdy_mode = 1;
    one_shot = 1'b1;
    push_seq();
    enable = 1'b1;
    wait_sb_empty("os_drain");
    wait_idle("os_idle");
    repeat (20) @(negedge clk);
    #1;
    check("os_stay_idle", busy, 0);
    check("os_no_valid", cmd_valid, 0);
    check("os_seqcnt", seq_cnt, 6);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    push_seq();
    enable = 1'b1;
    wait_sb_empty("os2_drain");
    wait_idle("os2_idle");
    check("os2_seqcnt", seq_cnt, 7);
    enable = 1'b0;
    one_shot = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // reset while command 7 is stalled
    push_seq();
    enable = 1'b1;
    wait_acc(5, "rst_acc5");
    rdy_mode = 0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_valid && cmd_count == 8'd7) break;
      @(negedge clk); #1;
    end
    check("stall_at_7", {cmd_valid, cmd_count}, 9'h107);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", cmd_valid, 0);
    check("arst_count", cmd_count, 0);
    check("arst_last", cmd_last, 0);
    check("arst_busy", busy, 0);
    check("arst_seqcnt", seq_cnt, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    push_seq();
    rdy_mode = 1;
    rst = 1'b1;

    // enable dropped after 5 is accepted: sequence still completes
    wait_acc(5, "drop_acc5");
    enable = 1'b0;
    wait_sb_empty("drop_drain");
    wait_idle("drop_idle");
    check("drop_seqcnt", seq_cnt, 1);

    // degenerate bound
    en2 = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    en2 = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy2) break;
      @(negedge clk); #1;
    end
    check("deg_idle", busy2, 0);
    check("deg_final_cnt", seq_cnt2, n2);
    check("deg_any", (n2 >= 5) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
